fp_addsub_pipe: RTL and testbench



---
 rtl/fp_addsub_pipe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Parametrised IEEE-754 adder/subtractor, 4-stage pipeline.
// Rounds to nearest even, flushes denormal inputs and tiny results to zero,
// and resolves NaN/inf operands in the first stage as a bypass result.
//
// Handshake: adv = !out_valid | out_ready. in_ready = adv. A transfer
// happens on a rising edge where in_valid & in_ready. Every stage register
// loads only when adv is high, so a stalled output freezes the whole pipe
// and result/flags stay stable while out_valid & !out_ready.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;          // significand with hidden bit
    localparam int AW  = MAN_W + 3;          // significand plus guard, round
    localparam int NW  = MAN_W + 4;          // significand plus G, R, sticky
    localparam int XW  = EXP_W + 2;          // signed exponent working width
    localparam int LZW = $clog2(NW + 1);
    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [W-1:0]        QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] ONE_X   = 1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, swap, specials ----------------
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] ea, eb, big_e, sml_e, diff;
    logic [MAN_W-1:0] fa, fb, fa_f, fb_f;
    logic [SW-1:0]    big_sig, sml_sig;
    logic             big_s, eff_sub, sp;
    logic [W-1:0]     sp_res;
    logic [3:0]       sp_flags;

    // Unpack operands, order by magnitude and pick any special-value result
    always_comb begin
        sa = a[W-1];
        ea = a[W-2:MAN_W];
        fa = a[MAN_W-1:0];
        sb = b[W-1] ^ op_sub;
        eb = b[W-2:MAN_W];
        fb = b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        fa_f   = a_zero ? '0 : fa;
        fb_f   = b_zero ? '0 : fb;
        if ({ea, fa_f} >= {eb, fb_f}) begin
            big_s = sa; big_e = ea; big_sig = {!a_zero, fa_f};
            sml_e = eb; sml_sig = {!b_zero, fb_f};
        end else begin
            big_s = sb; big_e = eb; big_sig = {!b_zero, fb_f};
            sml_e = ea; sml_sig = {!a_zero, fa_f};
        end
        diff     = big_e - sml_e;
        eff_sub  = sa ^ sb;
        sp       = a_nan || b_nan || a_inf || b_inf;
        sp_res   = QNAN;
        sp_flags = '0;
        if (a_nan || b_nan) begin
            sp_res = QNAN;
        end else if (a_inf && b_inf && eff_sub) begin
            sp_flags = 4'b1000;
        end else if (a_inf) begin
            sp_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sp_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid, s1_sign, s1_eff_sub, s1_sp;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [SW-1:0]    s1_big_sig, s1_sml_sig;
    logic [W-1:0]     s1_sp_res;
    logic [3:0]       s1_sp_flags;

    // S1 register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid;
            s1_sign     <= big_s;
            s1_exp      <= big_e;
            s1_diff     <= diff;
            s1_big_sig  <= big_sig;
            s1_sml_sig  <= sml_sig;
            s1_eff_sub  <= eff_sub;
            s1_sp       <= sp;
            s1_sp_res   <= sp_res;
            s1_sp_flags <= sp_flags;
        end
    end

    // ---------------- S2: align smaller operand ----------------
    logic [2*AW-1:0] wide;
    logic [AW-1:0]   aligned;
    logic            sticky;

    // Right-shift the smaller significand, collecting shifted-out bits as sticky
    always_comb begin
        wide = {s1_sml_sig, 2'b00, {AW{1'b0}}} >> s1_diff;
        if (int'(s1_diff) >= AW) begin
            aligned = '0;
            sticky  = |s1_sml_sig;
        end else begin
            aligned = wide[2*AW-1:AW];
            sticky  = |wide[AW-1:0];
        end
    end

    logic             s2_valid, s2_sign, s2_eff_sub, s2_sp;
    logic [EXP_W-1:0] s2_exp;
    logic [NW-1:0]    s2_big, s2_sml;
    logic [W-1:0]     s2_sp_res;
    logic [3:0]       s2_sp_flags;

    // S2 register
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_big      <= {s1_big_sig, 3'b000};
            s2_sml      <= {aligned, sticky};
            s2_eff_sub  <= s1_eff_sub;
            s2_sp       <= s1_sp;
            s2_sp_res   <= s1_sp_res;
            s2_sp_flags <= s1_sp_flags;
        end
    end

    // ---------------- S3: add/sub and leading-zero count ----------------
    logic [NW:0]     sum;
    logic [LZW-1:0]  lzc;
    logic            found;

    // Magnitude sum or difference (never negative after the swap), then LZC
    always_comb begin
        sum   = s2_eff_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                           : ({1'b0, s2_big} + {1'b0, s2_sml});
        lzc   = LZW'(NW);
        found = 1'b0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lzc   = LZW'(NW - 1 - i);
                found = 1'b1;
            end
        end
    end

    logic             s3_valid, s3_sign, s3_eff_sub, s3_sp;
    logic [EXP_W-1:0] s3_exp;
    logic [NW:0]      s3_sum;
    logic [LZW-1:0]   s3_lzc;
    logic [W-1:0]     s3_sp_res;
    logic [3:0]       s3_sp_flags;

    // S3 register
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
        end else if (adv) begin
            s3_valid    <= s2_valid;
            s3_sign     <= s2_sign;
            s3_exp      <= s2_exp;
            s3_sum      <= sum;
            s3_lzc      <= lzc;
            s3_eff_sub  <= s2_eff_sub;
            s3_sp       <= s2_sp;
            s3_sp_res   <= s2_sp_res;
            s3_sp_flags <= s2_sp_flags;
        end
    end

    // ---------------- S4: normalise, round, pack ----------------
    logic [NW-1:0]          norm;
    logic signed [XW-1:0]   e4;
    logic [SW:0]            mant;
    logic [MAN_W-1:0]       frac;
    logic                   rnd_up, inex;
    logic [W-1:0]           n_res;
    logic [3:0]             n_flags;

    // Normalise, round to nearest even, then detect overflow / flush underflow
    always_comb begin
        norm    = '0;
        e4      = $signed({2'b00, s3_exp});
        mant    = '0;
        frac    = '0;
        rnd_up  = 1'b0;
        inex    = 1'b0;
        n_res   = '0;
        n_flags = '0;
        if (s3_sum == '0) begin
            // Exact cancellation gives +0; adding two zeros keeps their sign
            n_res = {s3_eff_sub ? 1'b0 : s3_sign, {(W-1){1'b0}}};
        end else begin
            if (s3_sum[NW]) begin
                norm = {s3_sum[NW:2], s3_sum[1] | s3_sum[0]};
                e4   = e4 + ONE_X;
            end else begin
                norm = s3_sum[NW-1:0] << s3_lzc;
                e4   = e4 - $signed({{(XW-LZW){1'b0}}, s3_lzc});
            end
            inex = |norm[2:0];
            if (e4[XW-1] || e4 == '0) begin
                n_res   = {s3_sign, {(W-1){1'b0}}};
                n_flags = 4'b0011;
            end else begin
                rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
                mant   = {1'b0, norm[NW-1:3]} + {{SW{1'b0}}, rnd_up};
                if (mant[SW]) begin
                    e4   = e4 + ONE_X;
                    frac = mant[MAN_W:1];
                end else begin
                    frac = mant[MAN_W-1:0];
                end
                if (e4 >= $signed({2'b00, EXP_ONES})) begin
                    n_res   = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
                    n_flags = 4'b0101;
                end else begin
                    n_res   = {s3_sign, e4[EXP_W-1:0], frac};
                    n_flags = {3'b000, inex};
                end
            end
        end
    end

    // Output register; special-value bypass overrides the arithmetic result
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= s3_valid;
            result    <= !s3_valid ? '0 : (s3_sp ? s3_sp_res : n_res);
            flags     <= !s3_valid ? '0 : (s3_sp ? s3_sp_flags : n_flags);
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single precision instance plus a
// half precision instance, latency, rounding, exceptions, stall and reset.
module tb_fp_addsub_pipe;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    fp_addsub_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .op_sub(h_op_sub), .out_valid(h_out_valid),
        .out_ready(out_ready), .result(h_result), .flags(h_flags)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_rx    = 0;
    bit mon_en  = 1'b0;
    logic [35:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stream monitor: compares the head of the expected queue, pops on transfer
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (exp_q.size() == 0) begin
                check("stream_spurious", 32'(out_valid), 32'd0);
            end else begin
                check("stream_res", result, exp_q[0][31:0]);
                check("stream_flg", 32'(flags), 32'(exp_q[0][35:32]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_rx++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_vec(input string tag, input bit hp, input logic [31:0] va,
                           input logic [31:0] vb, input logic vop,
                           input logic [31:0] er, input logic [3:0] ef);
        int   cyc;
        logic ov;
        @(negedge clk);
        if (hp) begin
            h_a = va[15:0]; h_b = vb[15:0]; h_op_sub = vop; h_in_valid = 1'b1;
        end else begin
            a = va; b = vb; op_sub = vop; in_valid = 1'b1;
        end
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        in_valid   = 1'b0;
        h_in_valid = 1'b0;
        ov = hp ? h_out_valid : out_valid;
        while (!ov && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            ov = hp ? h_out_valid : out_valid;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd4);
        check({tag, "_res"}, hp ? {16'h0000, h_result} : result, er);
        check({tag, "_flg"}, 32'(hp ? h_flags : flags), 32'(ef));
    endtask

    logic [31:0] st_a[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h3F800000, 32'h41200000, 32'h3F000000, 32'hC0400000};
    logic [31:0] st_b[8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000,
                             32'h40000000, 32'h3F800000, 32'h3F000000, 32'hC0000000};
    logic        st_op[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] st_r[8] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h41000000,
                             32'hBF800000, 32'h41300000, 32'h3F800000, 32'hC0A00000};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_spur;
        reset = 1'b1; in_valid = 1'b0; h_in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op_sub = 1'b0; h_a = '0; h_b = '0; h_op_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_hp_valid",  32'(h_out_valid), 32'd0);

        // Directed vectors: basic arithmetic, rounding, exceptions
        run_vec("one_plus_one",  1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        run_vec("x_minus_x",     1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        run_vec("one_plus_mtwo", 1'b0, 32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 4'b0000);
        run_vec("tie_even_down", 1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_vec("tie_even_up",   1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        run_vec("overflow",      1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_vec("inf_minus_inf", 1'b0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_vec("nan_in",        1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        run_vec("inf_plus_one",  1'b0, 32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000);
        run_vec("denorm_flush",  1'b0, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
        run_vec("neg_zeros",     1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_vec("underflow",     1'b0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        run_vec("hp_one_one",    1'b1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 4'b0000);
        run_vec("hp_overflow",   1'b1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 4'b0101);

        // Back-to-back stream with a 3-cycle output stall
        for (int i = 0; i < 8; i++) exp_q.push_back({4'b0000, st_r[i]});
        n_rx   = 0;
        mon_en = 1'b1;
        fork
            begin : drv
                bit acc;
                int guard;
                @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++) begin
                    a = st_a[i]; b = st_b[i]; op_sub = st_op[i]; in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!acc && guard < 50);
                end
                in_valid = 1'b0;
            end
            begin : stall
                repeat (6) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk);
                end
                #2 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 100 && n_rx < 8; k++) @(posedge clk);
        check("stream_count", n_rx, 32'd8);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Reset with three operations in flight
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a = st_a[i]; b = st_b[i]; op_sub = st_op[i]; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result",    result,         32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        n_spur = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n_spur++;
        end
        check("midrst_no_stale", n_spur, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
